muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one radix-2 step per cycle
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [RD_W-1:0] rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [RD_W-1:0]   r_rd;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_dvs;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;
    logic [RD_W-1:0]   r_rd_out;

    logic              w_a_signed, w_b_signed, w_sa, w_sb, w_neg_in;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic              w_div0, w_ovf, w_special, w_accept, w_last;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN:0]     w_lhs, w_rhs;
    logic [XLEN+1:0]   w_sum;
    logic [2*XLEN-1:0] w_acc_next, w_prod;
    logic [XLEN-1:0]   w_div_pick, w_div_res, w_mul_res, w_final;

    // Signed operand decode: MUL/MULH/DIV/REM sign both, MULHSU only a
    assign w_a_signed = (!op[2] && (op[1:0] != 2'b11)) || (op[2] && !op[0]);
    assign w_b_signed = (!op[2] && !op[1]) || (op[2] && !op[0]);
    assign w_sa       = w_a_signed && a[XLEN-1];
    assign w_sb       = w_b_signed && b[XLEN-1];
    assign w_neg_in   = (op[2] && op[1]) ? w_sa : (w_sa ^ w_sb);
    assign w_a_mag    = w_sa ? (~a + 1'b1) : a;
    assign w_b_mag    = w_sb ? (~b + 1'b1) : b;

    assign w_div0        = op[2] && (b == '0);
    assign w_ovf         = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_special     = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign w_accept      = (r_state == S_IDLE) && start && !flush;
    assign w_last        = (r_count == CW'(XLEN-1));

    // Shared adder: adds the multiplicand, or subtracts the divisor from the shifted remainder
    assign w_rem = r_acc[2*XLEN-1:XLEN];
    assign w_lhs = r_op[2] ? {w_rem, r_acc[XLEN-1]} : {1'b0, w_rem};
    assign w_rhs = r_op[2] ? ~{1'b0, r_dvs} : {1'b0, r_dvs};
    assign w_sum = {1'b0, w_lhs} + {1'b0, w_rhs} + {{(XLEN+1){1'b0}}, r_op[2]};

    always_comb begin
        w_acc_next = r_acc;
        if (r_op[2]) begin
            if (w_sum[XLEN+1])
                w_acc_next = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            else
                w_acc_next = {w_lhs[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            if (r_acc[0])
                w_acc_next = {w_sum[XLEN:0], r_acc[XLEN-1:1]};
            else
                w_acc_next = {1'b0, w_rem, r_acc[XLEN-1:1]};
        end
    end

    // The product is negated over its full width so the high half carries correctly
    assign w_prod     = r_neg ? -w_acc_next : w_acc_next;
    assign w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign w_div_pick = r_op[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
    assign w_div_res  = r_neg ? -w_div_pick : w_div_pick;
    assign w_final    = r_op[2] ? w_div_res : w_mul_res;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_special ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_rd     <= '0;
            r_count  <= '0;
            r_dvs    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_neg   <= w_neg_in;
            r_rd    <= rd_in;
            r_count <= '0;
            r_dvs   <= w_b_mag;
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
            if (w_special) begin
                r_result <= w_special_res;
                r_rd_out <= rd_in;
            end
        end else if (r_state == S_CALC && !flush) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_result <= w_final;
                r_rd_out <= r_rd;
            end
        end
    end

    assign busy   = w_accept || (r_state == S_CALC);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - random and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (o)
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux * uy); return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = 64'(sx / sy); return p[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sx % sy); return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    // Model: cycles left until the result appears, plus the visible result/tag
    int          m_left = 0;
    bit          m_done = 1'b0, m_was_done;
    logic [31:0] m_result = 32'd0, m_pend = 32'd0;
    logic [4:0]  m_rd = 5'd0, m_pend_rd = 5'd0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left = 0; m_done = 1'b0; m_result = 32'd0; m_rd = 5'd0;
        end else begin
            m_was_done = m_done;
            m_done = 1'b0;
            if (flush) begin
                m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1; m_result = m_pend; m_rd = m_pend_rd;
                end
            end else if (start && !m_was_done) begin
                if (is_special(op, a, b)) begin
                    m_done = 1'b1; m_result = ref_calc(op, a, b); m_rd = rd_in;
                end else begin
                    m_left = 32; m_pend = ref_calc(op, a, b); m_pend_rd = rd_in;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", {63'd0, busy},
            {63'd0, resetn && (m_left > 0 || (!m_done && start && !flush))});
        chk("cyc_done", {63'd0, done}, {63'd0, m_done});
        chk("cyc_result", {32'd0, result}, {32'd0, m_result});
        chk("cyc_rd_out", {59'd0, rd_out}, {59'd0, m_rd});
    end

    // Issue one op right after a rising edge; returns after the DONE cycle, in IDLE
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat, busy_cnt;
        start = 1'b1; op = o; a = x; b = y; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        chk({name, "_result"}, {32'd0, result}, {32'd0, exp});
        chk({name, "_rd_out"}, {59'd0, rd_out}, {59'd0, rd});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] prev;
        int seen;

        chk("ref_mul", {32'd0, ref_calc(3'd0, 32'd7, 32'hFFFF_FFFD)}, 64'hFFFF_FFEB);
        chk("ref_mulhu", {32'd0, ref_calc(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFE);
        chk("ref_div", {32'd0, ref_calc(3'd4, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFD);
        chk("ref_rem", {32'd0, ref_calc(3'd6, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFF);
        chk("ref_mulhsu", {32'd0, ref_calc(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_rd_out", {59'd0, rd_out}, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 32);
        run_op("mulh",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 32);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd3,  32'hFFFF_FFFD, 32);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFF, 32);
        run_op("divu",   3'd5, 32'd100,        32'd7,         5'd6,  32'd14,        32);
        run_op("divu0",  3'd5, 32'd5,          32'd0,         5'd7,  32'hFFFF_FFFF, 0);
        run_op("rem0",   3'd6, 32'd5,          32'd0,         5'd8,  32'd5,         0);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 0);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'd0,         0);

        // Flush in CALC cycle 10, then an immediate new op
        prev = result;
        start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3; rd_in = 5'd11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_done", {63'd0, done}, 64'd0);
        chk("flush_result", {32'd0, result}, {32'd0, prev});
        run_op("after_flush", 3'd5, 32'd9, 32'd3, 5'd12, 32'd3, 32);

        // Start and flush together: nothing may happen
        start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; rd_in = 5'd13;
        #1 chk("sf_busy_now", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("sf_busy_after", {63'd0, busy}, 64'd0);
        seen = 0;
        repeat (36) begin @(posedge clk); #1; if (done) seen++; end
        chk("sf_no_done", 64'(seen), 64'd0);

        // Reset pulse in CALC cycle 20
        start = 1'b1; op = 3'd0; a = 32'd123; b = 32'd456; rd_in = 5'd14;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_result", {32'd0, result}, 64'd0);
        chk("arst_rd_out", {59'd0, rd_out}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        chk("arst_no_done", 64'(seen), 64'd0);
        run_op("mul_6x7", 3'd0, 32'd6, 32'd7, 5'd15, 32'd42, 32);

        // Random traffic: starts while busy, flushes, special operands
        for (int c = 0; c < 4000; c++) begin
            int mode;
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 49) == 0);
            op    = 3'($urandom);
            rd_in = 5'($urandom);
            mode  = $urandom_range(0, 7);
            case (mode)
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 20)) - 32'd10; b = 32'($urandom_range(0, 20)) - 32'd10; end
                default: begin a = $urandom; b = $urandom; end
            endcase
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
